// File: rtl/mem_fill_arbiter.sv
// Shared-memory fill sequencer for I/D caches; ARB_ROUND_ROBIN_EN selects round-robin miss arbitration.
// Latency: request seen in IDLE at T, reads at T+1..T+8, cache writes one cycle after each return, meta write after the last.
// Backpressure: none on memory; the stall output freezes the pipeline while any request is pending or in service.
module mem_fill_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] fill_data,
  output logic              i_cache_wen,
  output logic              d_cache_wen,
  output logic              i_meta_wen,
  output logic              d_meta_wen,
  output logic              stall
);

  localparam int OFF_W   = $clog2(WORDS);
  localparam int BLK_LSB = OFF_W + 1;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_FILL  = 2'd2;
  localparam logic [1:0] S_META  = 2'd3;

  logic [1:0]              state;
  logic [ADDR_W-1:BLK_LSB] blk_q;
  logic                    tgt_d;
  logic [OFF_W-1:0]        issue_cnt;
  logic [OFF_W-1:0]        ret_cnt;
  logic                    issue_done;
  logic                    ret_done;
  logic [ADDR_W-1:0]       wr_addr_q;
  logic [DATA_W-1:0]       wr_data_q;
  logic                    grant_wr;
  logic                    grant_d;
  logic                    grant_i;
  logic                    ret_ok;
  logic                    unused_addr_bits;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;
`endif

  // Only the block part of a miss address matters; words are always fetched from offset 0.
  assign unused_addr_bits = ^{i_miss_addr[BLK_LSB-1:0], d_miss_addr[BLK_LSB-1:0]};

  always_comb begin
    grant_wr = d_wr_req;
    grant_d  = 1'b0;
    grant_i  = 1'b0;
    if (!d_wr_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (d_miss && i_miss) begin
        grant_d = !last_d;
        grant_i = last_d;
      end else begin
        grant_d = d_miss;
        grant_i = i_miss;
      end
`else
      grant_d = d_miss;
      grant_i = !d_miss && i_miss;
`endif
    end
  end

  // Returns beyond the eighth word, or outside a fill, never reach a cache.
  assign ret_ok = (state == S_FILL) && mem_rvalid && !ret_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      blk_q       <= '0;
      tgt_d       <= 1'b0;
      issue_cnt   <= '0;
      ret_cnt     <= '0;
      issue_done  <= 1'b0;
      ret_done    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      fill_data   <= '0;
      i_cache_wen <= 1'b0;
      d_cache_wen <= 1'b0;
    end else begin
      i_cache_wen <= ret_ok && !tgt_d;
      d_cache_wen <= ret_ok && tgt_d;
      if (ret_ok) begin
        fill_data <= mem_rdata;
      end
      case (state)
        S_IDLE: begin
          issue_cnt  <= '0;
          ret_cnt    <= '0;
          issue_done <= 1'b0;
          ret_done   <= 1'b0;
          if (grant_wr) begin
            state     <= S_WRITE;
            wr_addr_q <= d_wr_addr;
            wr_data_q <= d_wr_data;
          end else if (grant_d || grant_i) begin
            state <= S_FILL;
            tgt_d <= grant_d;
            blk_q <= grant_d ? d_miss_addr[ADDR_W-1:BLK_LSB] : i_miss_addr[ADDR_W-1:BLK_LSB];
          end
        end
        S_WRITE: state <= S_IDLE;
        S_FILL: begin
          if (!issue_done) begin
            if (issue_cnt == LAST_WORD) begin
              issue_done <= 1'b1;
            end else begin
              issue_cnt <= issue_cnt + 1'b1;
            end
          end
          if (ret_ok) begin
            ret_cnt <= ret_cnt + 1'b1;
            if (ret_cnt == LAST_WORD) begin
              ret_done <= 1'b1;
            end
          end
          // Leave one cycle for the last word's cache write before the meta pulse.
          if (ret_done) begin
            state <= S_META;
          end
        end
        S_META:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d <= 1'b0;
    end else if (state == S_IDLE && !grant_wr && (grant_d || grant_i)) begin
      last_d <= grant_d;
    end
  end
`endif

  assign mem_en     = (state == S_WRITE) || ((state == S_FILL) && !issue_done);
  assign mem_wr     = (state == S_WRITE);
  assign mem_addr   = (state == S_WRITE) ? wr_addr_q :
                      ((state == S_FILL) && !issue_done) ? {blk_q, issue_cnt, 1'b0} : '0;
  assign mem_wdata  = (state == S_WRITE) ? wr_data_q : '0;
  assign i_meta_wen = (state == S_META) && !tgt_d;
  assign d_meta_wen = (state == S_META) && tgt_d;
  // Reset gates the request terms so every output is low while rst is asserted.
  assign stall      = rst && ((state != S_IDLE) || i_miss || d_miss || d_wr_req);

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench for mem_fill_arbiter with a 4-cycle pipelined memory model.
module tb_mem_fill_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss, d_miss, d_wr_req;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, fill_data;
  logic        i_cache_wen, d_cache_wen, i_meta_wen, d_meta_wen, stall;

  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  typedef struct {
    logic        is_d;
    logic [15:0] addr;
    logic [15:0] tag;
    logic [15:0] exp_blk;
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  mem_fill_arbiter dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .fill_data(fill_data),
    .i_cache_wen(i_cache_wen), .d_cache_wen(d_cache_wen),
    .i_meta_wen(i_meta_wen), .d_meta_wen(d_meta_wen),
    .stall(stall)
  );

  // Memory model: a read strobed in cycle C is returned during cycle C+4; data = tag + word offset.
  logic [3:0]  p_vld = 4'b0;
  logic [15:0] p_dat [4];
  logic [15:0] mem_tag = 16'h0;
  logic        inject = 1'b0;

  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = 16'h0;
    for (int i = 0; i < 4; i++) p_dat[i] = 16'h0;
  end

  always @(negedge clk) begin
    mem_rvalid = p_vld[3];
    mem_rdata  = p_dat[3];
    for (int i = 3; i > 0; i--) begin
      p_vld[i] = p_vld[i-1];
      p_dat[i] = p_dat[i-1];
    end
    p_vld[0] = (mem_en && !mem_wr) || inject;
    p_dat[0] = mem_tag + {13'd0, mem_addr[3:1]};
  end

  function automatic logic [6:0] mk(input logic en, input logic wr, input logic iw, input logic dw,
                                    input logic im, input logic dm, input logic st);
    return {en, wr, iw, dw, im, dm, st};
  endfunction

  function automatic logic [6:0] ctl();
    return {mem_en, mem_wr, i_cache_wen, d_cache_wen, i_meta_wen, d_meta_wen, stall};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s got=%h want=%h at %0t", phase, nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input logic st);
    @(negedge clk);
    chk("idle_ctl", 32'(ctl()), 32'(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, st)));
  endtask

  // Called at the negedge of the grant cycle T; checks cycles T+1..T+14 (ends in META).
  task automatic check_fill(input logic exp_d, input logic [15:0] blk, input logic [15:0] tag,
                            input int drop_k);
    logic en_e, wen_e, meta_e;
    mem_tag = tag;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == drop_k) begin
        if (exp_d) d_miss = 1'b0;
        else       i_miss = 1'b0;
      end
      @(negedge clk);
      en_e   = (k <= 8);
      wen_e  = (k >= 6) && (k <= 13);
      meta_e = (k == 14);
      chk($sformatf("ctl_k%0d", k), 32'(ctl()),
          32'(mk(en_e, 1'b0, wen_e && !exp_d, wen_e && exp_d, meta_e && !exp_d, meta_e && exp_d, 1'b1)));
      if (en_e) chk($sformatf("addr_k%0d", k), 32'(mem_addr), 32'(blk + 16'((k - 1) * 2)));
      if (wen_e) chk($sformatf("fill_k%0d", k), 32'(fill_data), 32'(tag + 16'(k - 6)));
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctl"}, 32'(ctl()), 32'd0);
    chk({nm, "_addr"}, 32'(mem_addr), 32'd0);
    chk({nm, "_wdata"}, 32'(mem_wdata), 32'd0);
    chk({nm, "_fill"}, 32'(fill_data), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{is_d: 1'b0, addr: 16'h1236, tag: 16'h00A0, exp_blk: 16'h1230};
    vecs[1] = '{is_d: 1'b1, addr: 16'h2BCF, tag: 16'h5500, exp_blk: 16'h2BC0};
    vecs[2] = '{is_d: 1'b1, addr: 16'h0000, tag: 16'hFFF8, exp_blk: 16'h0000};
    vecs[3] = '{is_d: 1'b0, addr: 16'hFFFE, tag: 16'h7F00, exp_blk: 16'hFFF0};

    rst = 1'b0;
    i_miss = 1'b1; i_miss_addr = 16'h1236;
    d_miss = 1'b0; d_miss_addr = 16'h0;
    d_wr_req = 1'b1; d_wr_addr = 16'h0100; d_wr_data = 16'h1234;

    // Reset: outputs low even with requests present.
    phase = "reset";
    @(negedge clk); @(negedge clk);
    chk_all_zero("rst");
    tick();
    i_miss = 1'b0; d_wr_req = 1'b0;
    rst = 1'b1;
    idle_chk(1'b0);

    // Single fills from the vector table.
    for (int v = 0; v < 4; v++) begin
      phase = $sformatf("vec%0d", v);
      tick();
      if (vecs[v].is_d) begin d_miss = 1'b1; d_miss_addr = vecs[v].addr; end
      else begin i_miss = 1'b1; i_miss_addr = vecs[v].addr; end
      idle_chk(1'b1);
      check_fill(vecs[v].is_d, vecs[v].exp_blk, vecs[v].tag, 0);
      tick(); i_miss = 1'b0; d_miss = 1'b0;
      idle_chk(1'b0);
      tick();
      idle_chk(1'b0);
    end

    // Simultaneous misses, then a second tie right after the D fill.
    phase = "tie";
    tick();
    i_miss = 1'b1; i_miss_addr = 16'h0040;
    d_miss = 1'b1; d_miss_addr = 16'h0080;
    idle_chk(1'b1);
    check_fill(1'b1, 16'h0080, 16'h1100, 0);
    tick(); d_miss_addr = 16'h00C0;
    idle_chk(1'b1);
`ifdef ARB_ROUND_ROBIN_EN
    check_fill(1'b0, 16'h0040, 16'h2200, 0);
    tick(); i_miss = 1'b0;
    idle_chk(1'b1);
    check_fill(1'b1, 16'h00C0, 16'h3300, 0);
    tick(); d_miss = 1'b0;
    idle_chk(1'b0);
`else
    check_fill(1'b1, 16'h00C0, 16'h3300, 0);
    tick(); d_miss = 1'b0;
    idle_chk(1'b1);
    check_fill(1'b0, 16'h0040, 16'h2200, 0);
    tick(); i_miss = 1'b0;
    idle_chk(1'b0);
`endif

    // Write-through wins over a pending D miss.
    phase = "write";
    tick();
    d_wr_req = 1'b1; d_wr_addr = 16'h0100; d_wr_data = 16'hBEEF;
    d_miss = 1'b1; d_miss_addr = 16'h0200;
    idle_chk(1'b1);
    tick(); d_wr_req = 1'b0;
    @(negedge clk);
    chk("wr_ctl", 32'(ctl()), 32'(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)));
    chk("wr_addr", 32'(mem_addr), 32'h0100);
    chk("wr_data", 32'(mem_wdata), 32'hBEEF);
    tick();
    idle_chk(1'b1);
    check_fill(1'b1, 16'h0200, 16'h4400, 0);
    tick(); d_miss = 1'b0;
    idle_chk(1'b0);

    // Reset during the fill while the fourth word is being returned.
    phase = "rst_mid";
    tick();
    i_miss = 1'b1; i_miss_addr = 16'h0A0A;
    idle_chk(1'b1);
    mem_tag = 16'h5550;
    for (int k = 1; k <= 7; k++) tick();
    @(negedge clk);
    chk("pre_rst_ctl", 32'(ctl()), 32'(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1)));
    tick();
    rst = 1'b0; i_miss = 1'b0;
    #1;
    chk_all_zero("mid");
    tick();
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      idle_chk(1'b0);
      tick();
    end

    // Miss drops early; the fill still runs to completion.
    phase = "drop";
    d_miss = 1'b1; d_miss_addr = 16'h3458;
    idle_chk(1'b1);
    check_fill(1'b1, 16'h3450, 16'h6600, 2);
    tick();
    idle_chk(1'b0);

    // Stray return while idle.
    phase = "stray";
    tick(); inject = 1'b1;
    idle_chk(1'b0);
    tick(); inject = 1'b0;
    idle_chk(1'b0);
    for (int k = 0; k < 7; k++) begin
      tick();
      idle_chk(1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
